// File: rtl/data_memory_unit.sv
// data_memory_unit
//   Data-side load/store target for the MEM stage. Decodes the bus onto a
//   byte-addressable RAM and three memory-mapped registers:
//     0x8000_0000 UART_DATA (store pushes a byte into the TX FIFO, reads 0)
//     0x8000_0004 STATUS    (busy/full/empty/misalign/overflow/count)
//     0x8000_0008 CYCLE     (free-running counter, writable)
//   Loads are combinational; every state change happens on the rising edge.
//
// Ports
//   CLK           clock
//   RST           synchronous reset, active low
//   MEM_alu_out   byte address
//   MEM_mem_in    store data
//   MEM_MemLen    access size/sign (000 B, 001 H, 010 W, 100 BU, 101 HU)
//   MEM_MemRead   load strobe
//   MEM_MemWrite  store strobe
//   MEM_mem_out   load data (combinational)
//   uart_tx       serial output, idles high
module data_memory_unit #(
   parameter int WIDTH      = 32,
   parameter int MEM_WORDS  = 1024,
   parameter int FIFO_DEPTH = 8,
   parameter int CLK_DIV    = 434
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic [WIDTH-1:0] MEM_alu_out,
   input  logic [WIDTH-1:0] MEM_mem_in,
   input  logic [2:0]       MEM_MemLen,
   input  logic             MEM_MemRead,
   input  logic             MEM_MemWrite,
   output logic [WIDTH-1:0] MEM_mem_out,
   output logic             uart_tx
);

   localparam int AW = $clog2(MEM_WORDS);
   localparam int FW = $clog2(FIFO_DEPTH);
   localparam int CW = $clog2(CLK_DIV);

   localparam logic [WIDTH-1:0] ADDR_UART   = WIDTH'(32'h8000_0000);
   localparam logic [WIDTH-1:0] ADDR_STATUS = WIDTH'(32'h8000_0004);
   localparam logic [WIDTH-1:0] ADDR_CYCLE  = WIDTH'(32'h8000_0008);

   typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} tx_state_t;

   // ---------------- state ----------------
   tx_state_t       r_state;
   logic            r_tx;
   logic [CW-1:0]   r_baud;
   logic [2:0]      r_bit_idx;
   logic [7:0]      r_shift;
   logic [FW-1:0]   r_wr_ptr;
   logic [FW-1:0]   r_rd_ptr;
   logic [FW:0]     r_count;
   logic [7:0]      r_fifo [FIFO_DEPTH];
   logic [WIDTH-1:0] r_cycle;
   logic            r_misalign;
   logic            r_overflow;

   // ---------------- decode ----------------
   logic             w_is_byte, w_is_half, w_is_word, w_misalign;
   logic             w_ram_sel, w_sel_uart, w_sel_status, w_sel_cycle;
   logic             w_wr_ok, w_ram_we, w_push_req, w_status_clr, w_cycle_ld;
   logic             w_misalign_evt;
   logic [AW-1:0]    w_word_idx;
   logic [3:0]       w_be;
   logic [WIDTH-1:0] w_wdata;

   assign w_is_byte  = (MEM_MemLen == 3'b000) || (MEM_MemLen == 3'b100);
   assign w_is_half  = (MEM_MemLen == 3'b001) || (MEM_MemLen == 3'b101);
   assign w_is_word  = !w_is_byte && !w_is_half;
   assign w_misalign = (w_is_half && MEM_alu_out[0]) ||
                       (w_is_word && (MEM_alu_out[1:0] != 2'b00));

   assign w_ram_sel    = (MEM_alu_out[WIDTH-1:AW+2] == '0);
   assign w_sel_uart   = (MEM_alu_out[WIDTH-1:2] == ADDR_UART[WIDTH-1:2]);
   assign w_sel_status = (MEM_alu_out[WIDTH-1:2] == ADDR_STATUS[WIDTH-1:2]);
   assign w_sel_cycle  = (MEM_alu_out[WIDTH-1:2] == ADDR_CYCLE[WIDTH-1:2]);
   assign w_word_idx   = MEM_alu_out[AW+1:2];

   assign w_wr_ok      = MEM_MemWrite && !w_misalign;
   assign w_ram_we     = w_wr_ok && w_ram_sel;
   assign w_push_req   = w_wr_ok && w_sel_uart;
   assign w_status_clr = w_wr_ok && w_sel_status;
   assign w_cycle_ld   = w_wr_ok && w_sel_cycle;
   // Misalignment is only flagged for accesses that hit a mapped location.
   assign w_misalign_evt = (MEM_MemRead || MEM_MemWrite) && w_misalign &&
                           (w_ram_sel || w_sel_uart || w_sel_status || w_sel_cycle);

   // Narrow stores replicate the data across lanes; the byte enables pick
   // which lanes actually land.
   always_comb begin
      w_be    = 4'b1111;
      w_wdata = MEM_mem_in;
      if (w_is_byte) begin
         w_be    = 4'b0001 << MEM_alu_out[1:0];
         w_wdata = {4{MEM_mem_in[7:0]}};
      end else if (w_is_half) begin
         w_be    = MEM_alu_out[1] ? 4'b1100 : 4'b0011;
         w_wdata = {2{MEM_mem_in[15:0]}};
      end
   end

   // ---------------- RAM: one byte-wide array per lane ----------------
   logic [WIDTH-1:0] w_ram_word;

   generate
      for (genvar gi = 0; gi < 4; gi++) begin : g_lane
         logic [7:0] r_lane [MEM_WORDS];
         always_ff @(posedge CLK) begin
            if (w_ram_we && w_be[gi]) begin
               r_lane[w_word_idx] <= w_wdata[gi*8 +: 8];
            end
         end
         assign w_ram_word[gi*8 +: 8] = r_lane[w_word_idx];
      end
   endgenerate

   // ---------------- FIFO / status ----------------
   logic w_fifo_full, w_fifo_empty, w_bit_end, w_push, w_pop, w_ovf_evt;
   logic [WIDTH-1:0] w_status;

   assign w_fifo_full  = (r_count == (FW+1)'(FIFO_DEPTH));
   assign w_fifo_empty = (r_count == '0);
   assign w_bit_end    = (r_baud == CW'(CLK_DIV-1));
   assign w_push       = w_push_req && !w_fifo_full;
   assign w_ovf_evt    = w_push_req && w_fifo_full;
   // Pop from IDLE, or at the end of a stop bit for back-to-back frames.
   assign w_pop        = !w_fifo_empty &&
                         ((r_state == S_IDLE) || ((r_state == S_STOP) && w_bit_end));

   assign w_status = {{(WIDTH-16){1'b0}}, 8'(r_count), 3'b000, r_overflow,
                      r_misalign, w_fifo_empty, w_fifo_full, (r_state != S_IDLE)};

   // ---------------- load path ----------------
   logic [7:0]  w_lane_byte;
   logic [15:0] w_lane_half;

   assign w_lane_byte = w_ram_word[{MEM_alu_out[1:0], 3'b000} +: 8];
   assign w_lane_half = w_ram_word[{MEM_alu_out[1], 4'b0000} +: 16];

   always_comb begin
      MEM_mem_out = '0;
      if (MEM_MemRead && !w_misalign) begin
         if (w_ram_sel) begin
            case (MEM_MemLen)
               3'b000:  MEM_mem_out = {{(WIDTH-8){w_lane_byte[7]}}, w_lane_byte};
               3'b100:  MEM_mem_out = {{(WIDTH-8){1'b0}}, w_lane_byte};
               3'b001:  MEM_mem_out = {{(WIDTH-16){w_lane_half[15]}}, w_lane_half};
               3'b101:  MEM_mem_out = {{(WIDTH-16){1'b0}}, w_lane_half};
               default: MEM_mem_out = w_ram_word;
            endcase
         end else if (w_sel_status) begin
            MEM_mem_out = w_status;
         end else if (w_sel_cycle) begin
            MEM_mem_out = r_cycle;
         end
      end
   end

   // FIFO storage is not reset; the pointers define what is valid.
   always_ff @(posedge CLK) begin
      if (w_push) begin
         r_fifo[r_wr_ptr] <= MEM_mem_in[7:0];
      end
   end

   // ---------------- control state + serializer ----------------
   always_ff @(posedge CLK) begin
      if (!RST) begin
         r_state    <= S_IDLE;
         r_tx       <= 1'b1;
         r_baud     <= '0;
         r_bit_idx  <= '0;
         r_shift    <= '0;
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_count    <= '0;
         r_cycle    <= '0;
         r_misalign <= 1'b0;
         r_overflow <= 1'b0;
      end else begin
         r_cycle <= w_cycle_ld ? MEM_mem_in : r_cycle + WIDTH'(1);

         if (w_push) r_wr_ptr <= r_wr_ptr + FW'(1);
         if (w_pop)  r_rd_ptr <= r_rd_ptr + FW'(1);
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + (FW+1)'(1);
            2'b01:   r_count <= r_count - (FW+1)'(1);
            default: r_count <= r_count;
         endcase

         // A clearing store is always aligned and never targets UART_DATA,
         // so it cannot coincide with a set event.
         if (w_misalign_evt) r_misalign <= 1'b1;
         if (w_ovf_evt)      r_overflow <= 1'b1;
         if (w_status_clr) begin
            r_misalign <= 1'b0;
            r_overflow <= 1'b0;
         end

         case (r_state)
            S_IDLE: begin
               if (!w_fifo_empty) begin
                  r_state <= S_START;
                  r_tx    <= 1'b0;
                  r_shift <= r_fifo[r_rd_ptr];
                  r_baud  <= '0;
               end
            end
            S_START: begin
               if (w_bit_end) begin
                  r_state   <= S_DATA;
                  r_tx      <= r_shift[0];
                  r_bit_idx <= '0;
                  r_baud    <= '0;
               end else begin
                  r_baud <= r_baud + CW'(1);
               end
            end
            S_DATA: begin
               if (w_bit_end) begin
                  r_baud <= '0;
                  if (r_bit_idx == 3'd7) begin
                     r_state <= S_STOP;
                     r_tx    <= 1'b1;
                  end else begin
                     r_bit_idx <= r_bit_idx + 3'd1;
                     r_shift   <= r_shift >> 1;
                     r_tx      <= r_shift[1];
                  end
               end else begin
                  r_baud <= r_baud + CW'(1);
               end
            end
            default: begin // S_STOP
               if (w_bit_end) begin
                  r_baud <= '0;
                  if (!w_fifo_empty) begin
                     r_state <= S_START;
                     r_tx    <= 1'b0;
                     r_shift <= r_fifo[r_rd_ptr];
                  end else begin
                     r_state <= S_IDLE;
                     r_tx    <= 1'b1;
                  end
               end else begin
                  r_baud <= r_baud + CW'(1);
               end
            end
         endcase
      end
   end

   assign uart_tx = r_tx;

endmodule

// File: tb/tb_data_memory_unit.sv
// tb_data_memory_unit
//   Table-driven load/store vectors, randomized RAM traffic against a byte-array
//   reference model, and hand-written sequences for CYCLE, UART framing,
//   FIFO overflow and mid-frame reset.
module tb_data_memory_unit;

   localparam int MW   = 64;          // RAM words -> 256 bytes
   localparam int FD   = 8;
   localparam int DIV  = 4;
   localparam int RAMB = MW * 4;

   localparam logic [31:0] A_UART   = 32'h8000_0000;
   localparam logic [31:0] A_STATUS = 32'h8000_0004;
   localparam logic [31:0] A_CYCLE  = 32'h8000_0008;

   logic        CLK = 1'b0;
   logic        RST = 1'b0;
   logic [31:0] MEM_alu_out = '0;
   logic [31:0] MEM_mem_in = '0;
   logic [2:0]  MEM_MemLen = 3'b010;
   logic        MEM_MemRead = 1'b0;
   logic        MEM_MemWrite = 1'b0;
   logic [31:0] MEM_mem_out;
   logic        uart_tx;

   data_memory_unit #(
      .WIDTH(32), .MEM_WORDS(MW), .FIFO_DEPTH(FD), .CLK_DIV(DIV)
   ) dut (
      .CLK(CLK), .RST(RST),
      .MEM_alu_out(MEM_alu_out), .MEM_mem_in(MEM_mem_in),
      .MEM_MemLen(MEM_MemLen), .MEM_MemRead(MEM_MemRead),
      .MEM_MemWrite(MEM_MemWrite), .MEM_mem_out(MEM_mem_out),
      .uart_tx(uart_tx)
   );

   always #5 CLK = ~CLK;

   int n_pass  = 0;
   int n_total = 0;

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      n_total++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", name, got, exp);
   endtask

   // ---------------- serial monitor ----------------
   logic tx_log[$];
   logic mon_en = 1'b0;

   always @(posedge CLK) begin
      if (mon_en) begin
         #1;
         tx_log.push_back(uart_tx);
      end
   end

   // ---------------- bus helpers ----------------
   // One bus cycle: drive at negedge, capture combinational load data, let
   // the next rising edge commit, then drop the strobes.
   task automatic cyc(input logic w, input logic r, input logic [31:0] a,
                      input logic [31:0] d, input logic [2:0] len,
                      output logic [31:0] q);
      @(negedge CLK);
      MEM_MemWrite = w; MEM_MemRead = r; MEM_alu_out = a;
      MEM_mem_in = d; MEM_MemLen = len;
      #1 q = MEM_mem_out;
      @(posedge CLK);
      #1;
      MEM_MemWrite = 1'b0; MEM_MemRead = 1'b0;
   endtask

   // Combinational read with no clock edge consumed.
   task automatic peek(input logic [31:0] a, input logic [2:0] len, output logic [31:0] q);
      MEM_alu_out = a; MEM_MemLen = len; MEM_MemRead = 1'b1; MEM_MemWrite = 1'b0;
      #1 q = MEM_mem_out;
      MEM_MemRead = 1'b0;
   endtask

   // ---------------- reference model ----------------
   logic [7:0] mem_model [RAMB];

   function automatic int acc_size(input logic [2:0] len);
      if (len == 3'b000 || len == 3'b100) return 1;
      if (len == 3'b001 || len == 3'b101) return 2;
      return 4;
   endfunction

   function automatic logic [31:0] model_load(input logic [31:0] a, input logic [2:0] len);
      int sz = acc_size(len);
      logic [31:0] v = 0;
      if (a >= RAMB || (a % sz) != 0) return 0;
      for (int i = 0; i < sz; i++) v = v | (32'(mem_model[a + i]) << (8 * i));
      if (len == 3'b000 && v[7])  v = v | 32'hFFFF_FF00;
      if (len == 3'b001 && v[15]) v = v | 32'hFFFF_0000;
      return v;
   endfunction

   task automatic model_store(input logic [31:0] a, input logic [31:0] d, input logic [2:0] len);
      int sz = acc_size(len);
      if (a >= RAMB || (a % sz) != 0) return;
      for (int i = 0; i < sz; i++) mem_model[a + i] = 8'(d >> (8 * i));
   endtask

   // Expected line level for one 8N1 frame, one entry per clock.
   function automatic logic [39:0] frame_bits(input logic [7:0] b);
      logic [39:0] f;
      for (int i = 0; i < 10 * DIV; i++) begin
         int k = i / DIV;
         if (k == 0)      f[i] = 1'b0;
         else if (k == 9) f[i] = 1'b1;
         else             f[i] = b[k-1];
      end
      return f;
   endfunction

   function automatic logic [39:0] log_frame(input int base);
      logic [39:0] f = '0;
      for (int i = 0; i < 10 * DIV; i++)
         if (base + i < tx_log.size()) f[i] = tx_log[base + i];
      return f;
   endfunction

   // ---------------- vector table ----------------
   typedef struct packed {
      logic        wr;
      logic [31:0] addr;
      logic [31:0] data;
      logic [2:0]  len;
      logic [31:0] exp;
   } vec_t;

   vec_t tbl[$];

   function automatic vec_t mk(input logic wr, input logic [31:0] a,
                               input logic [31:0] d, input logic [2:0] len,
                               input logic [31:0] exp);
      vec_t v;
      v.wr = wr; v.addr = a; v.data = d; v.len = len; v.exp = exp;
      return v;
   endfunction

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      logic [31:0] q;
      logic [7:0]  bytes_q[$];

      // ---- table contents ----
      tbl.push_back(mk(1, 32'h10, 32'h8081_82FF, 3'b010, 0));
      tbl.push_back(mk(0, 32'h10, 0, 3'b000, 32'hFFFF_FFFF));
      tbl.push_back(mk(0, 32'h11, 0, 3'b100, 32'h0000_0082));
      tbl.push_back(mk(0, 32'h12, 0, 3'b001, 32'hFFFF_8081));
      tbl.push_back(mk(0, 32'h10, 0, 3'b101, 32'h0000_82FF));
      tbl.push_back(mk(0, 32'h13, 0, 3'b000, 32'hFFFF_FF80));
      tbl.push_back(mk(0, 32'h12, 0, 3'b100, 32'h0000_0081));
      tbl.push_back(mk(0, 32'h10, 0, 3'b011, 32'h8081_82FF));
      tbl.push_back(mk(1, 32'h20, 32'h0, 3'b010, 0));
      tbl.push_back(mk(1, 32'h21, 32'h1234_56AA, 3'b000, 0));
      tbl.push_back(mk(0, 32'h20, 0, 3'b010, 32'h0000_AA00));
      tbl.push_back(mk(1, 32'h23, 32'h0000_BEEF, 3'b001, 0));
      tbl.push_back(mk(0, 32'h20, 0, 3'b010, 32'h0000_AA00));
      tbl.push_back(mk(0, A_STATUS, 0, 3'b010, 32'h0000_000C));
      tbl.push_back(mk(1, A_STATUS, 0, 3'b010, 0));
      tbl.push_back(mk(0, A_STATUS, 0, 3'b010, 32'h0000_0004));
      tbl.push_back(mk(0, 32'h11, 0, 3'b001, 32'h0));
      tbl.push_back(mk(0, A_STATUS, 0, 3'b000, 32'h0000_000C));
      tbl.push_back(mk(1, A_STATUS, 0, 3'b010, 0));
      tbl.push_back(mk(1, 32'h22, 32'h0000_CAFE, 3'b001, 0));
      tbl.push_back(mk(0, 32'h20, 0, 3'b010, 32'hCAFE_AA00));
      tbl.push_back(mk(0, 32'h12, 0, 3'b010, 32'h0));
      tbl.push_back(mk(1, A_STATUS, 0, 3'b010, 0));
      tbl.push_back(mk(1, 32'hFC, 32'hDEAD_BEEF, 3'b010, 0));
      tbl.push_back(mk(0, 32'hFC, 0, 3'b010, 32'hDEAD_BEEF));
      tbl.push_back(mk(1, 32'h0, 32'h0, 3'b010, 0));
      tbl.push_back(mk(1, 32'h100, 32'h1111_1111, 3'b010, 0));
      tbl.push_back(mk(0, 32'h100, 0, 3'b010, 32'h0));
      tbl.push_back(mk(0, 32'h0, 0, 3'b010, 32'h0));
      tbl.push_back(mk(0, A_UART, 0, 3'b010, 32'h0));
      tbl.push_back(mk(0, 32'h4000_0000, 0, 3'b010, 32'h0));

      // ---- reset and CYCLE ----
      RST = 1'b0;
      repeat (2) @(posedge CLK);
      #1 RST = 1'b1;
      @(negedge CLK);
      peek(A_STATUS, 3'b010, q); check("reset_status", q, 32'h0000_0004);
      check("reset_tx", uart_tx, 1'b1);
      peek(A_CYCLE, 3'b010, q);  check("reset_cycle", q, 32'h0);
      repeat (5) @(posedge CLK);
      @(negedge CLK);
      peek(A_CYCLE, 3'b010, q);  check("cycle_after_5", q, 32'd5);
      $display("cycle read after 5 edges: %h", q);
      cyc(1, 0, A_CYCLE, 32'hFFFF_FFFE, 3'b010, q);
      @(negedge CLK); peek(A_CYCLE, 3'b010, q); check("cycle_load", q, 32'hFFFF_FFFE);
      @(negedge CLK); peek(A_CYCLE, 3'b010, q); check("cycle_inc", q, 32'hFFFF_FFFF);
      @(negedge CLK); peek(A_CYCLE, 3'b010, q); check("cycle_wrap", q, 32'h0);
      @(negedge CLK); peek(A_CYCLE, 3'b000, q); check("cycle_byte_len_full", q, 32'h1);

      // ---- table-driven vectors ----
      foreach (tbl[i]) begin
         cyc(tbl[i].wr, !tbl[i].wr, tbl[i].addr, tbl[i].data, tbl[i].len, q);
         if (!tbl[i].wr) check($sformatf("vec%0d", i), q, tbl[i].exp);
         $display("vec %0d %s addr=%h len=%0d data=%h q=%h", i,
                  tbl[i].wr ? "st" : "ld", tbl[i].addr, tbl[i].len, tbl[i].data, q);
      end

      // ---- randomized RAM traffic ----
      for (int w = 0; w < MW; w++) begin
         logic [31:0] d = $urandom;
         cyc(1, 0, 32'(w * 4), d, 3'b010, q);
         model_store(32'(w * 4), d, 3'b010);
      end
      begin
         int rerr_before = n_total - n_pass;
         int nrd = 0;
         for (int t = 0; t < 400; t++) begin
            logic [2:0]  lens[8] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101, 3'b011, 3'b110, 3'b111};
            logic [31:0] a   = 32'($urandom_range(0, 2 * RAMB - 1));
            logic [31:0] d   = $urandom;
            logic [2:0]  len = lens[$urandom_range(0, 7)];
            int          op  = $urandom_range(0, 2);   // 0 load, 1 store, 2 both
            logic [31:0] exp = model_load(a, len);
            cyc(op != 0, op != 1, a, d, len, q);
            if (op != 1) begin
               check($sformatf("rand%0d a=%h len=%0d", t, a, len), q, exp);
               nrd++;
            end
            if (op != 0) model_store(a, d, len);
         end
         $display("random traffic: %0d loads checked, %0d mismatched", nrd,
                  (n_total - n_pass) - rerr_before);
      end
      cyc(1, 0, A_STATUS, 0, 3'b010, q);

      // ---- single frame 0x55 ----
      tx_log.delete();
      cyc(1, 0, A_UART, 32'h0000_0055, 3'b000, q);
      mon_en = 1'b1;
      repeat (10 * DIV) @(posedge CLK);
      cyc(0, 1, A_STATUS, 0, 3'b010, q); check("busy_at_end_of_stop", q, 32'h0000_0005);
      cyc(0, 1, A_STATUS, 0, 3'b010, q); check("idle_after_frame", q, 32'h0000_0004);
      mon_en = 1'b0;
      check("frame55_len", 64'(tx_log.size() >= 10 * DIV + 1), 64'd1);
      check("frame55", log_frame(0), frame_bits(8'h55));
      check("frame55_idle", 64'(log_frame(10 * DIV)) & 64'h1, 64'h1);
      $display("frame 0x55 line=%h", log_frame(0));

      // ---- 9 back-to-back bytes plus one overflow ----
      tx_log.delete();
      bytes_q.delete();
      for (int k = 0; k < 9; k++) bytes_q.push_back(8'($urandom));
      cyc(1, 0, A_UART, 32'(bytes_q[0]), 3'b000, q);
      mon_en = 1'b1;
      for (int k = 1; k < 9; k++) cyc(1, 0, A_UART, 32'(bytes_q[k]), 3'b000, q);
      cyc(1, 0, A_UART, 32'h0000_00EE, 3'b000, q);
      cyc(0, 1, A_STATUS, 0, 3'b010, q); check("status_full_overflow", q, 32'h0000_0813);
      for (int t = 0; t < 2000 && tx_log.size() < 9 * 10 * DIV + 2; t++) @(posedge CLK);
      #2;
      mon_en = 1'b0;
      check("burst_len", 64'(tx_log.size() >= 9 * 10 * DIV + 2), 64'd1);
      for (int k = 0; k < 9; k++) begin
         check($sformatf("burst_frame%0d", k), log_frame(k * 10 * DIV), frame_bits(bytes_q[k]));
         $display("burst frame %0d byte=%h line=%h", k, bytes_q[k], log_frame(k * 10 * DIV));
      end
      check("burst_idle", 64'(log_frame(9 * 10 * DIV)) & 64'h3, 64'h3);
      cyc(0, 1, A_STATUS, 0, 3'b010, q); check("overflow_sticky", q, 32'h0000_0014);
      cyc(1, 0, A_STATUS, 0, 3'b010, q);
      cyc(0, 1, A_STATUS, 0, 3'b010, q); check("overflow_cleared", q, 32'h0000_0004);

      // ---- reset in the middle of a data bit ----
      cyc(1, 0, A_UART, 32'h0000_003C, 3'b000, q);
      cyc(1, 0, A_UART, 32'h0000_0099, 3'b000, q);
      repeat (2 * DIV + 2) @(posedge CLK);
      @(negedge CLK);
      RST = 1'b0;
      @(posedge CLK);
      #1 RST = 1'b1;
      @(negedge CLK);
      check("rst_mid_tx", uart_tx, 1'b1);
      peek(A_STATUS, 3'b010, q); check("rst_mid_status", q, 32'h0000_0004);
      peek(A_CYCLE, 3'b010, q);  check("rst_mid_cycle", q, 32'h0);
      tx_log.delete();
      mon_en = 1'b1;
      repeat (12 * DIV) @(posedge CLK);
      #2;
      mon_en = 1'b0;
      begin
         int zeros = 0;
         foreach (tx_log[i]) if (tx_log[i] !== 1'b1) zeros++;
         check("rst_line_stays_idle", zeros, 0);
         $display("after mid-frame reset: %0d low samples in %0d", zeros, tx_log.size());
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
